// File: rtl/cpu24_ctrl_pkg.sv
// cpu24_ctrl_pkg: shared state encoding, opcode map and datapath select codes for the sequencer.
package cpu24_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED,
    S_ERROR
  } state_e;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] PC_PLUS1  = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b100;
  localparam logic [2:0] PC_JUMP   = 3'b010;

  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b100;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_ctrl_seq24_timer.sv
// mem_wait_timer: counts cycles a memory request waits; expired flags the wait that brings the count to TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = clr ? '0 : en ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count   = count_q;
  assign expired = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl_seq24.sv
// mc_ctrl_seq24: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared, time-bounded memory port.
module mc_ctrl_seq24
  import cpu24_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemAddrSel,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [2:0]       PCSel,
  output logic             RegWrite,
  output logic [2:0]       WBSel,
  output logic             Busy,
  output logic             Illegal,
  output logic             Halted,
  output logic             Error
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       op;
  logic             wait_en, expired;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, busy;
  logic [2:0]       pc_sel, wb_sel;

  assign op = 4'(Opcode);

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk    (Clock),
    .rst_n  (Reset),
    .clr    (state_d != state_q),
    .en     (wait_en),
    .count  (wait_cnt),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    wait_en   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_PLUS1;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    busy      = 1'b0;
    case (state_q)
      S_FETCH: if (Run) begin
        mem_read = 1'b1;
        busy     = 1'b1;
        wait_en  = !MemReady;
        ir_write = MemReady;
        pc_write = MemReady;
        state_d  = MemReady ? S_DECODE : expired ? S_ERROR : S_FETCH;
      end
      S_DECODE: begin
        busy      = 1'b1;
        illegal_d = illegal_q || !is_legal(op);
        state_d   = (op == OP_HALT) ? S_HALTED : is_legal(op) ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_FETCH;
        case (op)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          OP_BEQ: begin pc_write = Zero;  pc_sel = PC_BRANCH; end
          OP_BNE: begin pc_write = !Zero; pc_sel = PC_BRANCH; end
          OP_J:   begin pc_write = 1'b1;  pc_sel = PC_JUMP;   end
          default: ;
        endcase
      end
      S_MEM: begin
        busy      = 1'b1;
        addr_sel  = 1'b1;
        mem_read  = (op == OP_LW);
        mem_write = (op == OP_SW);
        wait_en   = !MemReady;
        state_d   = MemReady ? ((op == OP_LW) ? S_WB : S_FETCH) : expired ? S_ERROR : S_MEM;
      end
      S_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        wb_sel    = (op == OP_LW) ? WB_MEM : WB_ALU;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // The reset cycle itself must present no request or write enable.
  assign MemRead    = Reset && mem_read;
  assign MemWrite   = Reset && mem_write;
  assign MemAddrSel = Reset && addr_sel;
  assign IRWrite    = Reset && ir_write;
  assign PCWrite    = Reset && pc_write;
  assign PCSel      = Reset ? pc_sel : 3'b000;
  assign RegWrite   = Reset && reg_write;
  assign WBSel      = Reset ? wb_sel : 3'b000;
  assign Busy       = Reset && busy;
  assign Illegal    = Reset && illegal_q && (state_q != S_HALTED) && (state_q != S_ERROR);
  assign Halted     = Reset && (state_q == S_HALTED);
  assign Error      = Reset && (state_q == S_ERROR);

endmodule

// File: tb/tb_mc_ctrl_seq24.sv
// tb_mc_ctrl_seq24: directed per-cycle vectors queued as expected outputs, checked by an independent monitor.
module tb_mc_ctrl_seq24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, run = 1'b0, zero = 1'b0, rdy = 1'b0;
  logic [3:0] op = 4'b0000;
  logic       mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, busy, illegal, halted, error;
  logic [2:0] pc_sel, wb_sel;

  typedef struct {
    logic [15:0] v;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  mc_ctrl_seq24 dut (
    .Clock(clk), .Reset(rst_n), .Run(run), .Opcode(op), .Zero(zero), .MemReady(rdy),
    .MemRead(mem_read), .MemWrite(mem_write), .MemAddrSel(addr_sel), .IRWrite(ir_write),
    .PCWrite(pc_write), .PCSel(pc_sel), .RegWrite(reg_write), .WBSel(wb_sel),
    .Busy(busy), .Illegal(illegal), .Halted(halted), .Error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic mr, mw, as, ir, pw, input logic [2:0] pcs,
                                     input logic rw, input logic [2:0] wbs, input logic b, il, h, er);
    return {mr, mw, as, ir, pw, pcs, rw, wbs, b, il, h, er};
  endfunction

  function automatic logic [15:0] f_ok(input logic il);
    return ev(1, 0, 0, 1, 1, 3'b000, 0, 3'b000, 1, il, 0, 0);
  endfunction

  function automatic logic [15:0] bsy(input logic il);
    return ev(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, il, 0, 0);
  endfunction

  function automatic logic [15:0] idle(input logic il);
    return ev(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, il, 0, 0);
  endfunction

  task automatic cyc(input logic r, input logic rn, input logic rd, input logic z,
                     input logic [3:0] o, input logic [15:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; run = rn; rdy = rd; zero = z; op = o;
    step++;
    x.v = e;
    x.id = step;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      logic [15:0] act;
      x = exp_q.pop_front();
      act = {mem_read, mem_write, addr_sel, ir_write, pc_write, pc_sel,
             reg_write, wb_sel, busy, illegal, halted, error};
      total++;
      if (act !== x.v) begin
        bad++;
        $display("FAIL step%0d outputs got=%b want=%b", x.id, act, x.v);
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 4'h0, 16'h0);
    cyc(0, 0, 0, 0, 4'h0, 16'h0);
    // R-type: 4 cycles then back to idle FETCH
    cyc(1, 1, 1, 0, 4'h0, f_ok(0));
    cyc(1, 1, 1, 0, 4'h0, bsy(0));
    cyc(1, 1, 1, 0, 4'h0, bsy(0));
    cyc(1, 1, 1, 0, 4'h0, ev(0, 0, 0, 0, 0, 3'b000, 1, 3'b000, 1, 0, 0, 0));
    cyc(1, 0, 1, 0, 4'h0, idle(0));
    // LW with 3 stall cycles in MEM
    cyc(1, 1, 1, 0, 4'h2, f_ok(0));
    cyc(1, 1, 1, 0, 4'h2, bsy(0));
    cyc(1, 1, 1, 0, 4'h2, bsy(0));
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 4'h2, ev(1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, 4'h2, ev(1, 0, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, 4'h2, ev(0, 0, 0, 0, 0, 3'b000, 1, 3'b100, 1, 0, 0, 0));
    cyc(1, 0, 1, 0, 4'h2, idle(0));
    // BEQ taken, BNE not taken, BNE taken, J
    cyc(1, 1, 1, 1, 4'h4, f_ok(0));
    cyc(1, 1, 1, 1, 4'h4, bsy(0));
    cyc(1, 1, 1, 1, 4'h4, ev(0, 0, 0, 0, 1, 3'b100, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 0, 1, 1, 4'h4, idle(0));
    cyc(1, 1, 1, 1, 4'h5, f_ok(0));
    cyc(1, 1, 1, 1, 4'h5, bsy(0));
    cyc(1, 1, 1, 1, 4'h5, ev(0, 0, 0, 0, 0, 3'b100, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, 4'h5, f_ok(0));
    cyc(1, 1, 1, 0, 4'h5, bsy(0));
    cyc(1, 1, 1, 0, 4'h5, ev(0, 0, 0, 0, 1, 3'b100, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, 4'h6, f_ok(0));
    cyc(1, 1, 1, 0, 4'h6, bsy(0));
    cyc(1, 1, 1, 0, 4'h6, ev(0, 0, 0, 0, 1, 3'b010, 0, 3'b000, 1, 0, 0, 0));
    // SW with immediate ready, then ADDI
    cyc(1, 1, 1, 0, 4'h3, f_ok(0));
    cyc(1, 1, 1, 0, 4'h3, bsy(0));
    cyc(1, 1, 1, 0, 4'h3, bsy(0));
    cyc(1, 1, 1, 0, 4'h3, ev(0, 1, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0));
    cyc(1, 1, 1, 0, 4'h1, f_ok(0));
    cyc(1, 1, 1, 0, 4'h1, bsy(0));
    cyc(1, 1, 1, 0, 4'h1, bsy(0));
    cyc(1, 1, 1, 0, 4'h1, ev(0, 0, 0, 0, 0, 3'b000, 1, 3'b000, 1, 0, 0, 0));
    // illegal opcode acts as NOP, flag sticks across the next R-type
    cyc(1, 1, 1, 0, 4'hA, f_ok(0));
    cyc(1, 1, 1, 0, 4'hA, bsy(0));
    cyc(1, 1, 1, 0, 4'h0, f_ok(1));
    cyc(1, 1, 1, 0, 4'h0, bsy(1));
    cyc(1, 1, 1, 0, 4'h0, bsy(1));
    cyc(1, 1, 1, 0, 4'h0, ev(0, 0, 0, 0, 0, 3'b000, 1, 3'b000, 1, 1, 0, 0));
    cyc(1, 0, 1, 0, 4'h0, idle(1));
    // HALT is absorbing even with Run held high
    cyc(0, 0, 0, 0, 4'h0, 16'h0);
    cyc(1, 1, 1, 0, 4'hF, f_ok(0));
    cyc(1, 1, 1, 0, 4'hF, bsy(0));
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 4'hF, ev(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 0));
    // fetch timeout: 15 waiting cycles, then ERROR with request dropped
    cyc(0, 0, 0, 0, 4'h0, 16'h0);
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 4'h0, ev(1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc(1, 1, i == 1, 0, 4'h0, ev(0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1));
    cyc(0, 1, 0, 0, 4'h0, 16'h0);
    cyc(1, 0, 0, 0, 4'h0, idle(0));
    // reset while SW waits in MEM clears the write and the Illegal flag
    cyc(1, 1, 1, 0, 4'hA, f_ok(0));
    cyc(1, 1, 1, 0, 4'hA, bsy(0));
    cyc(1, 1, 1, 0, 4'h3, f_ok(1));
    cyc(1, 1, 1, 0, 4'h3, bsy(1));
    cyc(1, 1, 1, 0, 4'h3, bsy(1));
    cyc(1, 1, 0, 0, 4'h3, ev(0, 1, 1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 0, 0));
    cyc(0, 1, 0, 0, 4'h3, 16'h0);
    cyc(1, 0, 0, 0, 4'h3, idle(0));
    cyc(1, 1, 0, 0, 4'h3, ev(1, 0, 0, 0, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
